// File: rtl/tdm_demux.sv
// TDM demultiplexer: gathers LANES serial samples (lane 0 marked by in_sof) into one
// parallel frame presented with a valid/ready handshake. Define TDM_DEMUX_ERRCNT_EN for err_count.
module tdm_demux #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]             err_count
`endif
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FULL
  } state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic [WIDTH-1:0]         r_shadow [LANES];
  logic [LANES*WIDTH-1:0]   r_out_data;
  logic                     r_out_valid;

  logic                     w_accept;
  logic                     w_err;
  logic [LANES*WIDTH-1:0]   w_frame_last;
  logic [LANES*WIDTH-1:0]   w_frame_full;

  // NOTE: in_ready is decoded from the registered state only, so it never
  // depends on in_valid and cannot form a combinational loop with the source.
  assign in_ready  = (r_state != S_FULL);
  assign w_accept  = in_valid && in_ready;
  assign w_err     = w_accept && (((r_state == S_IDLE) && !in_sof) ||
                                  ((r_state == S_FILL) && in_sof));
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  // Frame images: the bypass form takes the final lane straight from in_data.
  always_comb begin
    w_frame_last = '0;
    w_frame_full = '0;
    for (int k = 0; k < LANES; k++) begin
      w_frame_full[k*WIDTH +: WIDTH] = r_shadow[k];
      if (k == LANES - 1) begin
        w_frame_last[k*WIDTH +: WIDTH] = in_data;
      end else begin
        w_frame_last[k*WIDTH +: WIDTH] = r_shadow[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      // NOTE: the shadow array is small and must read back as zero after reset,
      // so it is cleared explicitly instead of being left as plain storage.
      for (int k = 0; k < LANES; k++) begin
        r_shadow[k] <= '0;
      end
    end else begin
      // Consumed frame drops valid; a load on the same edge overrides below.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_accept && in_sof) begin
            r_shadow[0] <= in_data;
            r_cnt       <= CW'(1);
            r_state     <= S_FILL;
          end
        end

        S_FILL: begin
          if (w_accept) begin
            if (in_sof) begin
              r_shadow[0] <= in_data;
              r_cnt       <= CW'(1);
            end else if (r_cnt == LAST_LANE) begin
              if (!r_out_valid || out_ready) begin
                r_out_data  <= w_frame_last;
                r_out_valid <= 1'b1;
                r_cnt       <= '0;
                r_state     <= S_IDLE;
              end else begin
                r_shadow[LANES-1] <= in_data;
                r_state           <= S_FULL;
              end
            end else begin
              r_shadow[r_cnt] <= in_data;
              r_cnt           <= r_cnt + CW'(1);
            end
          end
        end

        S_FULL: begin
          if (out_ready) begin
            r_out_data  <= w_frame_full;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  logic w_err_unused;
  assign w_err_unused = w_err;
`endif

`ifndef SYNTHESIS
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (r_out_valid && !out_ready) |=> (r_out_valid && $stable(r_out_data)));
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    (int'(r_cnt) < LANES));
  a_full_valid: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_FULL) |-> r_out_valid);
`endif

endmodule
